// File: rtl/countdown_sequencer.sv
// ============================================================================
//  Module      : countdown_sequencer
//  Description : Control FSM that runs an external loadable down counter
//                through a programmed number of countdown rounds.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module countdown_sequencer #(
    parameter int WIDTH  = 4,
    parameter int RWIDTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic [WIDTH-1:0]  load_val,
    input  logic [RWIDTH-1:0] rounds,
    input  logic [WIDTH-1:0]  cnt,
    output logic              cnt_ld,
    output logic [WIDTH-1:0]  cnt_ld_val,
    output logic              cnt_en,
    output logic              busy,
    output logic              round_done,
    output logic              done,
    output logic [RWIDTH-1:0] rounds_left
);

    localparam logic [2:0] C_IDLE = 3'd0;
    localparam logic [2:0] C_LOAD = 3'd1;
    localparam logic [2:0] C_RUN  = 3'd2;
    localparam logic [2:0] C_HOLD = 3'd3;
    localparam logic [2:0] C_DONE = 3'd4;

    localparam logic [RWIDTH-1:0] C_ONE_ROUND = RWIDTH'(1);

    logic [2:0]        state_q, state_d;
    logic [WIDTH-1:0]  ld_val_q, ld_val_d;
    logic [RWIDTH-1:0] rounds_left_q, rounds_left_d;
    logic              round_done_q, round_done_d;
    logic              done_q, done_d;

    logic              w_cnt_zero;
    logic              w_accept;
    logic              w_round_end;

    assign w_cnt_zero  = (cnt == '0);
    assign w_accept    = (state_q == C_IDLE) && start && !stop;
    // A round only completes when not aborted in the same cycle.
    assign w_round_end = (state_q == C_RUN) && w_cnt_zero && !stop;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= C_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            C_IDLE: begin
                if (w_accept) begin
                    state_d = C_LOAD;
                end
            end
            C_LOAD: begin
                state_d = stop ? C_IDLE : C_RUN;
            end
            C_RUN: begin
                if (stop) begin
                    state_d = C_IDLE;
                end else if (w_cnt_zero) begin
                    state_d = (rounds_left_q == C_ONE_ROUND) ? C_DONE : C_LOAD;
                end else if (pause) begin
                    state_d = C_HOLD;
                end
            end
            C_HOLD: begin
                if (stop) begin
                    state_d = C_IDLE;
                end else if (!pause) begin
                    state_d = C_RUN;
                end
            end
            C_DONE: begin
                state_d = C_IDLE;
            end
            default: begin
                state_d = C_IDLE;
            end
        endcase
    end

    // Output decode
    always_comb begin
        cnt_ld      = (state_q == C_LOAD);
        cnt_en      = (state_q == C_RUN) && !w_cnt_zero && !pause && !stop;
        // Held high through the trailing done pulse so the run reads as busy until it retires.
        busy        = (state_q != C_IDLE) || done_q;
        cnt_ld_val  = ld_val_q;
        rounds_left = rounds_left_q;
        round_done  = round_done_q;
        done        = done_q;
    end

    // Run parameters and completion pulses
    always_comb begin
        ld_val_d      = ld_val_q;
        rounds_left_d = rounds_left_q;
        round_done_d  = w_round_end;
        done_d        = (state_q == C_DONE) && !stop;
        if (w_accept) begin
            ld_val_d      = load_val;
            rounds_left_d = (rounds == '0) ? C_ONE_ROUND : rounds;
        end else if (w_round_end) begin
            rounds_left_d = rounds_left_q - C_ONE_ROUND;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ld_val_q      <= '0;
            rounds_left_q <= '0;
            round_done_q  <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            ld_val_q      <= ld_val_d;
            rounds_left_q <= rounds_left_d;
            round_done_q  <= round_done_d;
            done_q        <= done_d;
        end
    end

endmodule

`default_nettype wire
